// File: rtl/seq_det_prog.sv
// seq_det_prog: run-time programmable serial pattern detector (shift/compare + fill counter).
// Optional match counter enabled by defining SEQ_DET_CNT_EN.
module seq_det_prog #(
   parameter int MAX_LEN = 16,
   parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'('h12),
   parameter int DEF_LEN = 5,
   parameter bit DEF_OVERLAP = 1'b1,
   parameter int CNT_W = 16,
   localparam int LW = $clog2(MAX_LEN+1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               seq_data,
   input  logic               seq_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LW-1:0]      cfg_len,
   input  logic               cfg_overlap,
   input  logic               cnt_clr,
   output logic               seq_det,
   output logic [CNT_W-1:0]   match_cnt
);
   logic [MAX_LEN-1:0] pattern, hist, cand, mask;
   logic [LW-1:0]      len, fill, new_len;
   logic [LW:0]        fill_p1;
   logic               overlap, match;
   logic [1:0]         unused_bits;

   // cand is the history including the incoming bit; len = MAX_LEN shifts the mask to all ones
   always_comb begin
      cand    = {hist[MAX_LEN-2:0], seq_data};
      mask    = ~({MAX_LEN{1'b1}} << len);
      fill_p1 = {1'b0, fill} + (LW+1)'(1);
      new_len = (cfg_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cfg_len;
      match   = seq_valid && !cfg_load && (len != '0) && (fill_p1 >= {1'b0, len})
                && (((cand ^ pattern) & mask) == '0);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pattern <= DEF_PATTERN;
         len     <= LW'(DEF_LEN);
         overlap <= DEF_OVERLAP;
         hist    <= '0;
         fill    <= '0;
         seq_det <= 1'b0;
      end else if (cfg_load) begin
         pattern <= cfg_pattern;
         len     <= new_len;
         overlap <= cfg_overlap;
         hist    <= '0;
         fill    <= '0;
         seq_det <= 1'b0;
      end else begin
         seq_det <= match;
         if (seq_valid) begin
            hist <= cand;
            fill <= (match && !overlap) ? '0 : (fill == len) ? fill : fill_p1[LW-1:0];
         end
      end
   end

`ifdef SEQ_DET_CNT_EN
   logic [CNT_W-1:0] cnt;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt <= '0;
      else if (cnt_clr) cnt <= '0;
      else if (match && cnt != '1) cnt <= cnt + CNT_W'(1);
   end
   assign match_cnt   = cnt;
   assign unused_bits = {1'b0, hist[MAX_LEN-1]};
`else
   assign match_cnt   = '0;
   assign unused_bits = {cnt_clr, hist[MAX_LEN-1]};
`endif
endmodule

// File: tb/tb_seq_det_prog.sv
// tb_seq_det_prog: directed scoreboard bench for seq_det_prog (CNT_W=2 so saturation is reachable).
module tb_seq_det_prog;
   localparam int MAX_LEN = 16;
   localparam int LW = $clog2(MAX_LEN+1);
   localparam int CNT_W = 2;

   logic clk = 1'b0, rst = 1'b1;
   logic seq_data = 1'b0, seq_valid = 1'b0, cfg_load = 1'b0, cfg_overlap = 1'b1, cnt_clr = 1'b0;
   logic [MAX_LEN-1:0] cfg_pattern = '0;
   logic [LW-1:0] cfg_len = '0;
   logic seq_det;
   logic [CNT_W-1:0] match_cnt;
   int vectors = 0, miscompares = 0;
   logic exp_q[$];
   string tag_q[$];

   seq_det_prog #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .seq_data(seq_data), .seq_valid(seq_valid),
      .cfg_load(cfg_load), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap), .cnt_clr(cnt_clr), .seq_det(seq_det), .match_cnt(match_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_det();
      logic e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      vectors++;
      assert (seq_det === e) else begin
         miscompares++;
         $error("FAIL %s: seq_det=%b expected=%b", t, seq_det, e);
      end
   endtask

   task automatic check_cnt(input logic [CNT_W-1:0] e, input string t);
      vectors++;
      assert (match_cnt === e) else begin
         miscompares++;
         $error("FAIL %s: match_cnt=%0d expected=%0d", t, match_cnt, e);
      end
   endtask

   // one clock: drive inputs, queue the expected seq_det, compare after the edge
   task automatic beat(input logic v, input logic d, input logic e, input string t);
      seq_valid = v;
      seq_data  = d;
      exp_q.push_back(e);
      tag_q.push_back(t);
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
      cnt_clr  = 1'b0;
      check_det();
   endtask

   task automatic load(input logic [MAX_LEN-1:0] p, input logic [LW-1:0] l, input logic o,
                       input logic v, input logic d);
      cfg_pattern = p;
      cfg_len     = l;
      cfg_overlap = o;
      cfg_load    = 1'b1;
      beat(v, d, 1'b0, "load");
   endtask

   task automatic stream(input logic [31:0] bits, input logic [31:0] exps, input int n,
                         input string t);
      for (int i = n - 1; i >= 0; i--) beat(1'b1, bits[i], exps[i], t);
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      exp_q.push_back(1'b0);
      tag_q.push_back("reset");
      check_det();
      check_cnt('0, "reset_cnt");
      rst = 1'b0;

      stream(32'b10010, 32'b00001, 5, "default");
      beat(1'b0, 1'b0, 1'b0, "pulse_one_cycle");

      load(16'h0012, 5'd5, 1'b1, 1'b0, 1'b0);
      stream(32'b10010010, 32'b00001001, 8, "overlap");

      load(16'h0012, 5'd5, 1'b0, 1'b0, 1'b0);
      stream(32'b10010010, 32'b00001000, 8, "no_overlap");

      load(16'h0012, 5'd5, 1'b1, 1'b0, 1'b0);
      for (int i = 4; i >= 0; i--) begin
         beat(1'b1, 5'b10010 >> i, i == 0, "gap_bit");
         repeat (3) beat(1'b0, 1'b1, 1'b0, "gap_idle");
      end

      load(16'h0005, 5'd3, 1'b1, 1'b1, 1'b1);
      stream(32'b0101, 32'b0001, 4, "load_wins");

      load(16'h0000, 5'd0, 1'b1, 1'b0, 1'b0);
      stream(32'b000, 32'b000, 3, "len0_disabled");

      load(16'hFFFF, 5'd31, 1'b1, 1'b0, 1'b0);
      stream(32'hFFFF, 32'h0001, 16, "len_clamp");

      cnt_clr = 1'b1;
      beat(1'b0, 1'b0, 1'b0, "cnt_clr_beat");
      check_cnt('0, "cnt_cleared");
      load(16'h0012, 5'd5, 1'b1, 1'b0, 1'b0);
      stream(32'b10010010010010010, 32'b00001001001001001, 17, "five_matches");
`ifdef SEQ_DET_CNT_EN
      check_cnt(2'd3, "cnt_saturated");
`else
      check_cnt(2'd0, "cnt_tied_off");
`endif
      cnt_clr = 1'b1;
      beat(1'b0, 1'b0, 1'b0, "cnt_clr_beat");
      check_cnt('0, "cnt_cleared_again");

      load(16'h0005, 5'd3, 1'b0, 1'b0, 1'b0);
      stream(32'b1001, 32'b0000, 4, "pre_reset");
      #2 rst = 1'b1;
      #1;
      exp_q.push_back(1'b0);
      tag_q.push_back("mid_reset");
      check_det();
      @(posedge clk);
      #1 rst = 1'b0;
      beat(1'b1, 1'b0, 1'b0, "after_reset");
      stream(32'b10010, 32'b00001, 5, "default_restored");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
